intr_responder: RTL
===================

// Module: intr_responder
// PURPOSE
//  CPU-side end of the interrupt request/acknowledge protocol. Samples O_intr/O_intr_vector
//  from the interrupt controller and waits for an instruction boundary. It then saves the
//  return PC, flushes and redirects fetch to the vector address, and pulses the acknowledge.
//  Interrupts stay masked until the ISR retires a reti. Sits between the interrupt
//  controller and the fetch/PC logic of the core.
// PARAMETERS
//  ADDR_W       32          PC / address width
//  VECTOR_BASE  32'h10      address of vector 0 slot
//  VEC_SHIFT    2           log2 bytes per vector slot; target = VECTOR_BASE + (vec << VEC_SHIFT)
// PORTS
//  I_clk          in   1       clock, all state on rising edge
//  I_rst          in   1       synchronous reset, active-low
//  I_intr         in   1       interrupt request level from controller
//  I_intr_vector  in   2       vector number, valid while I_intr=1
//  I_safe         in   1       pipeline at instruction boundary (no stall, no branch in flight)
//  I_pc           in   ADDR_W  PC of next instruction to execute, valid when I_safe=1
//  I_reti         in   1       reti instruction retiring this cycle
//  I_ie_set       in   1       software global interrupt enable set
//  I_ie_clr       in   1       software global interrupt enable clear
//  O_intr_ack     out  1       one-cycle acknowledge to controller
//  O_flush        out  1       one-cycle pipeline flush
//  O_redirect     out  1       one-cycle fetch redirect strobe
//  O_redirect_pc  out  ADDR_W  target PC, valid while O_redirect=1
//  O_epc          out  ADDR_W  saved return PC
//  O_in_isr       out  1       high from ENTER through RETURN inclusive
//  O_ie           out  1       global interrupt enable
// BEHAVIOUR
//  Reset (I_rst=0 at edge): state=IDLE, O_ie=1, O_epc=0, O_redirect_pc=0.
//   All strobes 0, O_in_isr=0. Reset mid-ISR abandons the ISR without acknowledge.
//   The controller is reset alongside.
//  All outputs registered. States: IDLE, ENTER, ISR, RETURN.
//  IDLE: take when I_intr & O_ie & I_safe & I_intr_vector!=0.
//   Edge: epc<=I_pc, vec latched, ->ENTER.
//  Spurious (IDLE, I_intr & O_ie & I_safe & vec==0): pulse O_intr_ack one cycle.
//   No flush, no redirect, no epc update, stay IDLE.
//  ENTER (1 cycle): O_intr_ack=O_flush=O_redirect=1.
//   O_redirect_pc=VECTOR_BASE+(vec<<VEC_SHIFT), truncated to ADDR_W.
//   O_ie<=0, ->ISR. Latency: take edge -> strobes visible next cycle.
//  ISR: ignore I_intr. On I_reti -> RETURN.
//  RETURN (1 cycle): O_flush=O_redirect=1, O_redirect_pc=O_epc, O_ie<=1, ->IDLE.
//  Earliest next take: first IDLE cycle after RETURN. No back-to-back without IDLE gap,
//   except with the optional feature below.
//  I_ie_set/I_ie_clr: honoured only in IDLE; clr wins if both; ignored in other states.
//  Simultaneous I_ie_clr and a take condition in IDLE: interrupt taken (ie sampled pre-edge).
//  I_reti outside ISR: ignored.
// CONFIGURATION
//  INTR_TAIL_CHAIN_EN defined: in ISR, if I_reti & I_intr & I_intr_vector!=0:
//   ->ENTER for the new vector, epc unchanged, O_ie stays 0, no RETURN redirect.
//   reti with vec==0: normal RETURN, plus a spurious ack in the same RETURN cycle.
//  Undefined: I_intr ignored throughout ISR; reti always ->RETURN.
// TESTING
//  1. Reset: I_rst=0 two cycles -> all strobes 0, O_ie=1, O_in_isr=0, O_epc=0.
//  2. I_intr=1, vec=1, I_safe=1, I_pc=0x100 -> next cycle ack/flush/redirect=1.
//     O_redirect_pc=0x14, O_epc=0x100, O_ie=0.
//     Then I_reti -> RETURN redirect to 0x100, O_ie=1.
//  3. I_intr=1 vec=2 with I_safe=0 for 3 cycles, then I_safe=1 -> ENTER one cycle later.
//     O_redirect_pc=0x18, O_epc = I_pc of the I_safe cycle.
//  4. Spurious vec=0 in IDLE -> single O_intr_ack, O_redirect=0, O_epc unchanged.
//     I_ie_clr then I_intr vec=1 -> never acked until I_ie_set.
//  5. In ISR, I_intr vec=2 plus I_reti same cycle:
//     without INTR_TAIL_CHAIN_EN -> RETURN to epc, then ENTER vec 2 after IDLE;
//     with it -> ENTER redirect to 0x18 directly, O_epc unchanged.
//  6. Assert I_rst=0 during ISR -> next cycle IDLE, O_ie=1, no ack/redirect emitted.

Source files
------------

// File: rtl/intr_responder.sv
// -----------------------------------------------------------------------------
// intr_responder
//
// CPU-side end of the interrupt request/acknowledge handshake. It samples the
// controller's request and vector, waits for an instruction boundary, saves the
// return PC, then flushes and redirects fetch to the vector slot while pulsing
// the acknowledge. Further interrupts stay masked until the ISR retires a reti,
// which redirects fetch back to the saved PC.
//
// Build option:
//   INTR_TAIL_CHAIN_EN  - when defined, a reti that retires while a valid
//                         interrupt is pending chains straight into the next
//                         ISR without returning first.
//
// Parameters:
//   ADDR_W       PC / address width
//   VECTOR_BASE  address of the vector 0 slot
//   VEC_SHIFT    log2 bytes per vector slot
//
// Ports:
//   I_clk          clock, all state on the rising edge
//   I_rst          synchronous reset, active low
//   I_intr         interrupt request level from the controller
//   I_intr_vector  vector number, valid while I_intr is high
//   I_safe         pipeline sits at an instruction boundary
//   I_pc           PC of the next instruction, valid while I_safe is high
//   I_reti         reti instruction retiring this cycle
//   I_ie_set       software global interrupt enable set
//   I_ie_clr       software global interrupt enable clear
//   O_intr_ack     one-cycle acknowledge to the controller
//   O_flush        one-cycle pipeline flush
//   O_redirect     one-cycle fetch redirect strobe
//   O_redirect_pc  redirect target, valid while O_redirect is high
//   O_epc          saved return PC
//   O_in_isr       high from entry through return inclusive
//   O_ie           global interrupt enable
// -----------------------------------------------------------------------------
module intr_responder #(
  parameter int          ADDR_W      = 32,
  parameter int unsigned VECTOR_BASE = 32'h10,
  parameter int          VEC_SHIFT   = 2
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_intr,
  input  logic [1:0]        I_intr_vector,
  input  logic              I_safe,
  input  logic [ADDR_W-1:0] I_pc,
  input  logic              I_reti,
  input  logic              I_ie_set,
  input  logic              I_ie_clr,
  output logic              O_intr_ack,
  output logic              O_flush,
  output logic              O_redirect,
  output logic [ADDR_W-1:0] O_redirect_pc,
  output logic [ADDR_W-1:0] O_epc,
  output logic              O_in_isr,
  output logic              O_ie
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    ISR    = 2'd2,
    RETURN = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              ie_q, ie_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              ack_q, ack_d;
  logic              flush_q, flush_d;
  logic              redirect_q, redirect_d;
  logic              in_isr_q, in_isr_d;

  logic              vec_nonzero;
  logic [ADDR_W-1:0] vec_target;
  logic              chain_take;
  logic              chain_spur_ack;

  assign vec_nonzero = (I_intr_vector != 2'd0);
  // Vector slot address, wrapped to the address width.
  assign vec_target  = ADDR_W'(VECTOR_BASE) + (ADDR_W'(I_intr_vector) << VEC_SHIFT);

`ifdef INTR_TAIL_CHAIN_EN
  // A reti that meets a live request re-enters directly; a vector-0 request at
  // that moment is acknowledged as spurious alongside the normal return.
  assign chain_take     = I_intr & vec_nonzero;
  assign chain_spur_ack = I_intr & ~vec_nonzero;
`else
  assign chain_take     = 1'b0;
  assign chain_spur_ack = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ie_d          = ie_q;
    epc_d         = epc_q;
    redirect_pc_d = redirect_pc_q;
    ack_d         = 1'b0;
    flush_d       = 1'b0;
    redirect_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (I_ie_clr) begin
          ie_d = 1'b0;
        end else if (I_ie_set) begin
          ie_d = 1'b1;
        end
        // Enable is judged on its pre-edge value, so a take wins over a
        // simultaneous software clear.
        if (I_intr && ie_q && I_safe) begin
          ack_d = 1'b1;
          if (vec_nonzero) begin
            state_d       = ENTER;
            epc_d         = I_pc;
            redirect_pc_d = vec_target;
            flush_d       = 1'b1;
            redirect_d    = 1'b1;
            ie_d          = 1'b0;
          end
        end
      end

      ENTER: begin
        state_d = ISR;
      end

      ISR: begin
        if (I_reti) begin
          flush_d    = 1'b1;
          redirect_d = 1'b1;
          if (chain_take) begin
            state_d       = ENTER;
            redirect_pc_d = vec_target;
            ack_d         = 1'b1;
          end else begin
            state_d       = RETURN;
            redirect_pc_d = epc_q;
            ie_d          = 1'b1;
            ack_d         = chain_spur_ack;
          end
        end
      end

      RETURN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_isr_d = (state_d != IDLE);
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      state_q       <= IDLE;
      ie_q          <= 1'b1;
      epc_q         <= '0;
      redirect_pc_q <= '0;
      ack_q         <= 1'b0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      in_isr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ie_q          <= ie_d;
      epc_q         <= epc_d;
      redirect_pc_q <= redirect_pc_d;
      ack_q         <= ack_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      in_isr_q      <= in_isr_d;
    end
  end

  assign O_intr_ack    = ack_q;
  assign O_flush       = flush_q;
  assign O_redirect    = redirect_q;
  assign O_redirect_pc = redirect_pc_q;
  assign O_epc         = epc_q;
  assign O_in_isr      = in_isr_q;
  assign O_ie          = ie_q;

endmodule
